clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_counter.sv | 59 +++++
 rtl/clk_div_ctrl.sv | 112 +++++++++++
 tb/tb_clk_div_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and types for the clock-divider controller slice.
//   CNT_W      : default width of the divide ratio and period counter
//   DEF_RATIO  : divide ratio loaded into the active register at reset
//   CLAMP_MIN  : smallest legal ratio; captured values below it are raised to it
//   state_e    : controller FSM states
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int CNT_W     = 8;
  localparam int DEF_RATIO = 2;
  localparam int CLAMP_MIN = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage : clk_div_pkg

// File: rtl/clk_div_counter.sv
// -----------------------------------------------------------------------------
// clk_div_counter
// Period counter, wrap detect and registered divided-clock generation.
//   clk_in   : divider input clock
//   rst_n    : asynchronous active-low reset
//   active   : controller is currently in RUN or DRAIN
//   go       : controller will be in RUN or DRAIN after this edge
//   act_r    : active divide ratio (always >= 2)
//   cnt      : position within the current output period, 0..act_r-1
//   wrap     : current cycle is the last of the period (cnt == act_r-1)
//   clk_out  : divided clock, straight from a flop
// -----------------------------------------------------------------------------
module clk_div_counter #(
  parameter int CNT_W = clk_div_pkg::CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             active,
  input  logic             go,
  input  logic [CNT_W-1:0] act_r,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   half;

  assign wrap = active && (cnt == act_r - CNT_W'(1));

  // NOTE: always_comb gives every output a value before any branch so no
  // path through the block leaves a signal unassigned (which would infer a latch).
  always_comb begin
    cnt_nxt = '0;
    if (active && !wrap) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
    // ceil(act_r/2), computed one bit wider so the +1 cannot overflow.
    half = ({1'b0, act_r} + (CNT_W + 1)'(1)) >> 1;
  end

  // The new period always starts at cnt=0, which is high for every legal ratio,
  // so a ratio change at the wrap cannot produce a runt pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (go) begin
      cnt     <= cnt_nxt;
      clk_out <= ({1'b0, cnt_nxt} < half);
    end else begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end
  end

endmodule : clk_div_counter

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Run/drain FSM and ratio-update handshake around clk_div_counter.
//   clk_in     : divider input clock, all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   en         : level-sensitive run request
//   cfg_valid  : new ratio offered on cfg_ratio
//   cfg_ratio  : requested divide ratio (0 and 1 are captured as 2)
//   cfg_ready  : a new ratio can be accepted (no ratio pending)
//   clk_out    : divided clock from a flop, glitch-free across ratio changes
//   div_tick   : high in the last clk_in cycle of each output period
//   ratio_upd  : high in the cycle whose closing edge loads the pending ratio
//   running    : high in RUN and DRAIN
// -----------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = clk_div_pkg::CNT_W,
  parameter int DEF_RATIO = clk_div_pkg::DEF_RATIO
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             div_tick,
  output logic             ratio_upd,
  output logic             running
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] act_r;
  logic [CNT_W-1:0] pending_r;
  logic             pending;
  logic [CNT_W-1:0] cfg_clamped;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             active;
  logic             go;
  logic             xfer;
  logic             apply;

  assign active      = (state != IDLE);
  assign go          = (state_nxt != IDLE);
  assign running     = active;
  assign cfg_ready   = !pending;
  assign xfer        = cfg_valid && cfg_ready;
  assign cfg_clamped = (cfg_ratio < CNT_W'(CLAMP_MIN)) ? CNT_W'(CLAMP_MIN) : cfg_ratio;

  // A pending ratio lands immediately when stopped, otherwise only at the
  // period boundary. xfer requires !pending, so a ratio accepted during a
  // wrap cycle waits for the next wrap.
  assign apply     = pending && ((state == IDLE) || wrap);
  assign ratio_upd = apply;
  assign div_tick  = wrap;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping en at the wrap cycle of RUN goes straight to IDLE: that period
  // has already completed, so DRAIN would only add an extra one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = wrap ? IDLE : DRAIN;
      DRAIN: begin
        if (en)        state_nxt = RUN;
        else if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      act_r     <= CNT_W'(DEF_RATIO);
      pending_r <= CNT_W'(DEF_RATIO);
      pending   <= 1'b0;
    end else begin
      if (apply) begin
        act_r   <= pending_r;
        pending <= 1'b0;
      end
      if (xfer) begin
        pending_r <= cfg_clamped;
        pending   <= 1'b1;
      end
    end
  end

  clk_div_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .active  (active),
    .go      (go),
    .act_r   (act_r),
    .cnt     (cnt),
    .wrap    (wrap),
    .clk_out (clk_out)
  );

endmodule : clk_div_ctrl

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Scoreboard bench for clk_div_ctrl. Each step drives inputs on the falling
// edge and queues the outputs expected after the next rising edge, packed as
// {clk_out, div_tick, ratio_upd, running, cfg_ready}. A monitor pops and
// compares one entry shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

  logic       clk_in;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_ratio;
  logic       cfg_ready;
  logic       clk_out;
  logic       div_tick;
  logic       ratio_upd;
  logic       running;

  typedef struct {
    int         id;
    logic [4:0] outs;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id  = 0;

  clk_div_ctrl #(
    .CNT_W     (8),
    .DEF_RATIO (2)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ratio (cfg_ratio),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .div_tick  (div_tick),
    .ratio_upd (ratio_upd),
    .running   (running)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_clk_out"},   32'(clk_out),   32'd0);
    check({tag, "_div_tick"},  32'(div_tick),  32'd0);
    check({tag, "_ratio_upd"}, 32'(ratio_upd), 32'd0);
    check({tag, "_running"},   32'(running),   32'd0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  // Drive one cycle of stimulus; exp is what the outputs show after its edge.
  task automatic step(input logic e, input logic v, input logic [7:0] r, input logic [4:0] exp);
    exp_t item;
    @(negedge clk_in);
    en        = e;
    cfg_valid = v;
    cfg_ratio = r;
    step_id++;
    item.id   = step_id;
    item.outs = exp;
    sb.push_back(item);
  endtask

  always @(posedge clk_in) begin
    #1;
    if (sb.size() != 0) begin
      exp_t item;
      item = sb.pop_front();
      check($sformatf("step%0d", item.id),
            32'({clk_out, div_tick, ratio_upd, running, cfg_ready}), 32'(item.outs));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_ratio = '0;
    #1 check_idle("por");
    repeat (2) @(posedge clk_in);
    #1 check_idle("rst_hold");
    @(negedge clk_in);
    rst_n = 1'b1;

    // Default ratio 2: clk_out toggles, tick on every cnt=1 cycle; stop from cnt=0.
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b01011);
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b01011);
    step(1, 0, 0, 5'b10011);
    step(0, 0, 0, 5'b01011);  // DRAIN finishes the period
    step(0, 0, 0, 5'b00001);  // back to IDLE

    // Ratio 5 loaded in IDLE: update pulse before running, then 1,1,1,0,0.
    step(0, 1, 5, 5'b00100);
    step(0, 0, 0, 5'b00001);
    for (int p = 0; p < 2; p++) begin
      step(1, 0, 0, 5'b10011);
      step(1, 0, 0, 5'b10011);
      step(1, 0, 0, 5'b10011);
      step(1, 0, 0, 5'b00011);
      step(1, 0, 0, 5'b01011);
    end
    step(1, 0, 0, 5'b10011);
    step(0, 0, 0, 5'b10011);  // en low at cnt=0, R=5 period completes
    step(0, 0, 0, 5'b10011);
    step(0, 0, 0, 5'b00011);
    step(0, 0, 0, 5'b01011);
    step(0, 0, 0, 5'b00001);

    // R=4 running, ratio 3 offered at cnt=1: applies at the wrap.
    step(0, 1, 4, 5'b00100);
    step(0, 0, 0, 5'b00001);
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b10011);
    step(1, 1, 3, 5'b00010);  // accepted, ready drops
    step(1, 0, 0, 5'b01110);  // wrap with update pulse
    step(1, 0, 0, 5'b10011);  // R=3: 1,1,0
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b01011);
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b01011);
    // Ratio 4 accepted during a wrap cycle: takes effect one period later.
    step(1, 1, 4, 5'b10010);
    step(1, 0, 0, 5'b10010);
    step(1, 0, 0, 5'b01110);
    step(1, 0, 0, 5'b10011);  // R=4: 1,1,0,0
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b00011);
    step(1, 0, 0, 5'b01011);

    // R=4, en dropped at cnt=1: period completes then IDLE.
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b10011);
    step(0, 0, 0, 5'b00011);
    step(0, 0, 0, 5'b01011);
    step(0, 0, 0, 5'b00001);
    step(0, 0, 0, 5'b00001);
    // en dropped at cnt=1, re-asserted at cnt=2: no gap, no truncation.
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b10011);
    step(0, 0, 0, 5'b00011);
    step(1, 0, 0, 5'b01011);
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b00011);
    step(1, 0, 0, 5'b01011);

    // en falls together with a ratio offer: ratio 3 still lands at the DRAIN wrap.
    step(1, 0, 0, 5'b10011);
    step(0, 1, 3, 5'b10010);
    step(0, 0, 0, 5'b00010);
    step(0, 0, 0, 5'b01110);
    step(0, 0, 0, 5'b00001);
    step(1, 0, 0, 5'b10011);  // R=3 confirmed
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b01011);
    step(1, 0, 0, 5'b10011);
    step(0, 0, 0, 5'b10011);
    step(0, 0, 0, 5'b01011);
    step(0, 0, 0, 5'b00001);

    // Ratio 0 clamps to 2; applied and started on the same edge.
    step(0, 1, 0, 5'b00100);
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b01011);
    step(1, 0, 0, 5'b10011);
    step(0, 0, 0, 5'b01011);
    step(0, 0, 0, 5'b00001);
    // Ratio 1 clamps to 2.
    step(0, 1, 1, 5'b00100);
    step(0, 0, 0, 5'b00001);
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b01011);
    step(1, 0, 0, 5'b10011);
    step(0, 0, 0, 5'b01011);
    step(0, 0, 0, 5'b00001);

    // R=6, asynchronous reset at cnt=1 while clk_out is high.
    step(0, 1, 6, 5'b00100);
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b10011);
    @(posedge clk_in);
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    #1 check_idle("async_rst");
    @(posedge clk_in);
    #1 check_idle("rst_edge");
    @(negedge clk_in);
    rst_n = 1'b1;
    step(0, 0, 0, 5'b00001);  // first edge only samples en
    step(1, 0, 0, 5'b10011);  // clean R=2 restart
    step(1, 0, 0, 5'b01011);
    step(1, 0, 0, 5'b10011);
    step(1, 0, 0, 5'b01011);

    @(posedge clk_in);
    #2;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_clk_div_ctrl
